// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the constants of the byte-stream frame format.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    // States in which a byte may be taken from the stream.
    function automatic logic is_receiving(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler for the loader: MSB-first shift register, byte
// position counter and running XOR checksum of every data byte.
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic                  xor_i,
    input  logic [7:0]            byte_i,
    output logic [31:0]           word_o,
    output logic [BYTE_CNT_W-1:0] byte_cnt_o,
    output logic [7:0]            csum_o
);

    logic [31:0]           word_q;
    logic [BYTE_CNT_W-1:0] byte_cnt_q;
    logic [7:0]            csum_q;

    // Clear wins over shift/xor so a restart always begins from a clean frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
        end else if (clear_i) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
        end else begin
            if (shift_i) begin
                word_q     <= {word_q[23:0], byte_i};
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
            if (xor_i) begin
                csum_q <= csum_q ^ byte_i;
            end
        end
    end

    assign word_o     = word_q;
    assign byte_cnt_o = byte_cnt_q;
    assign csum_o     = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into insMem while holding the CPU
// in reset; the CPU is released only after the full image and a good checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 2 ** ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic                  im_we_o,
    output logic [ADDR_WIDTH-1:0] im_addr_o,
    output logic [31:0]           im_wdata_o,
    output logic                  cpu_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic                  in_ready_q, im_we_q, cpu_rst_q, busy_q, done_q, error_q;

    logic                  accept;
    logic                  asm_clear, asm_shift, asm_xor;
    logic [31:0]           asm_word;
    logic [BYTE_CNT_W-1:0] asm_byte_cnt;
    logic [7:0]            asm_csum;
    logic [LEN_W-1:0]      len_full;

    loader_word_asm u_word_asm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (asm_clear),
        .shift_i    (asm_shift),
        .xor_i      (asm_xor),
        .byte_i     (in_data_i),
        .word_o     (asm_word),
        .byte_cnt_o (asm_byte_cnt),
        .csum_o     (asm_csum)
    );

    assign accept   = in_valid_i & in_ready_q;
    assign len_full = {len_q[LEN_W-1:8], in_data_i};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;
        asm_xor   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d   = ST_LEN_HI;
                    len_d     = '0;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data_i, len_q[7:0]};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d = ST_CSUM;
                    end else if (32'(len_full) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    asm_xor   = 1'b1;
                    if (asm_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1)) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Index is one bit wider than the address so N == MAX_WORDS ends cleanly.
                if (32'(idx_q) + 32'd1 < 32'(len_q)) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data_i == asm_csum) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            in_ready_q <= is_receiving(state_d);
            im_we_q    <= (state_d == ST_WRITE);
            cpu_rst_q  <= (state_d != ST_DONE);
            busy_q     <= is_receiving(state_d) || (state_d == ST_WRITE);
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERR);
        end
    end

    assign in_ready_o = in_ready_q;
    assign im_we_o    = im_we_q;
    assign im_addr_o  = idx_q[ADDR_WIDTH-1:0];
    assign im_wdata_o = asm_word;
    assign cpu_rst_o  = cpu_rst_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frame loads, checksum errors,
// length boundaries, stream stalls, mid-load reset and start handling.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, im_we, cpu_rst, busy, done, error;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;

    int tests = 0;
    int fails = 0;
    int wrCount = 0;
    int rdyViol = 0;
    int gapIdx = 0;
    bit useGaps = 1'b0;
    int gapPat[7] = '{0, 2, 1, 0, 3, 0, 1};

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .im_we_o    (im_we),
        .im_addr_o  (im_addr),
        .im_wdata_o (im_wdata),
        .cpu_rst_o  (cpu_rst),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    // Counts every write pulse and any write cycle that also offers in_ready.
    always @(negedge clk) begin
        if (im_we) begin
            wrCount++;
            if (in_ready) rdyViol++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_flags"}, 32'({in_ready, im_we, cpu_rst, busy, done, error}), 32'b001000);
        checkVal({tag, "_addr"}, 32'(im_addr), 32'h0);
        checkVal({tag, "_wdata"}, im_wdata, 32'h0);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n;
        if (useGaps) begin
            int g;
            g = gapPat[gapIdx % 7];
            gapIdx++;
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkVal("accept", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int idx);
        sendByte(w[31:24]);
        sendByte(w[23:16]);
        sendByte(w[15:8]);
        sendByte(w[7:0]);
        checkVal("we_pulse", 32'(im_we), 32'h1);
        checkVal("we_addr", 32'(im_addr), 32'(idx));
        checkVal("we_data", im_wdata, w);
        checkVal("we_ready", 32'(in_ready), 32'h0);
    endtask

    // Two-word image; XOR of its eight data bytes is 0x18.
    task automatic loadCase1();
        pulseStart();
        sendByte(8'h00);
        sendByte(8'h02);
        sendWord(32'h3C080005, 0);
        sendWord(32'h21090001, 1);
        sendByte(8'h18);
        checkVal("c1_flags", 32'({done, cpu_rst, error, busy}), 32'b1000);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        loadCase1();
        checkVal("c1_writes", 32'(wrCount), 32'd2);

        pulseStart();
        checkVal("c2_restart", 32'({cpu_rst, done, busy}), 32'b101);
        sendByte(8'h00);
        sendByte(8'h01);
        sendWord(32'h12345678, 0);
        sendByte(8'h00);
        checkVal("c2_flags", 32'({error, cpu_rst, done, busy}), 32'b1100);

        pulseStart();
        checkVal("c3_err_clr", 32'({error, busy}), 32'b01);
        sendByte(8'h00);
        sendByte(8'h00);
        checkVal("c3_n0_csum", 32'({busy, in_ready, im_we}), 32'b110);
        sendByte(8'h00);
        checkVal("c3_n0_done", 32'({done, cpu_rst, error}), 32'b100);
        checkVal("c3_n0_writes", 32'(wrCount), 32'd3);

        pulseStart();
        sendByte(8'h04);
        sendByte(8'h01);
        checkVal("c3_toolong", 32'({error, busy, in_ready, cpu_rst}), 32'b1001);

        pulseStart();
        sendByte(8'h04);
        sendByte(8'h00);
        checkVal("c3_maxlen", 32'({error, busy, in_ready}), 32'b011);
        rst_n = 1'b0;
        @(negedge clk);
        checkReset("c3_abort");
        rst_n = 1'b1;
        @(negedge clk);

        useGaps = 1'b1;
        loadCase1();
        useGaps = 1'b0;
        checkVal("c4_writes", 32'(wrCount), 32'd5);
        checkVal("c4_ready_viol", 32'(rdyViol), 32'd0);

        pulseStart();
        sendByte(8'h00);
        sendByte(8'h02);
        sendWord(32'h3C080005, 0);
        sendByte(8'h21);
        sendByte(8'h09);
        rst_n = 1'b0;
        #1;
        checkReset("c5_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loadCase1();
        checkVal("c5_writes", 32'(wrCount), 32'd8);

        pulseStart();
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'hAA);
        sendByte(8'hBB);
        pulseStart();
        checkVal("c6_ign_start", 32'({busy, in_ready, error, cpu_rst}), 32'b1101);
        sendByte(8'hCC);
        sendByte(8'hDD);
        checkVal("c6_we", 32'(im_we), 32'h1);
        checkVal("c6_word", im_wdata, 32'hAABBCCDD);
        sendByte(8'h00);
        checkVal("c6_done", 32'({done, cpu_rst}), 32'b10);

        pulseStart();
        checkVal("c6_restart", 32'({cpu_rst, done, busy}), 32'b101);
        sendByte(8'h00);
        sendByte(8'h01);
        sendWord(32'hDEADBEEF, 0);
        sendByte(8'h22);
        checkVal("c6_reload", 32'({done, cpu_rst, error}), 32'b100);
        checkVal("c6_writes", 32'(wrCount), 32'd10);
        checkVal("final_ready_viol", 32'(rdyViol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
